instruction_fetch_stage: RTL and testbench
==========================================

// Module: instruction_fetch_stage
// PURPOSE
//  Fetch stage plus IF/ID pipeline register. Owns the PC and issues one-outstanding requests to
//  instruction memory. Captures returned words into IF/ID for decode. Honours the active-low stall
//  (stalln) from the hazard detection unit and the branch/jump redirect from EX.
//  Sits between imem and the decode stage; IF/ID outputs feed decode and the hazard unit's rs1/rs2.
// PARAMETERS
//  XLEN      32            data/address width
//  RESET_PC  32'h0000_0000 PC after reset (bits [1:0] must be 0)
//  NOP_INSTR 32'h0000_0013 value of if_id_instr when no valid instruction (addi x0,x0,0)
// PORTS
//  clk            in   1     single clock, rising edge
//  rst            in   1     asynchronous, active-high reset
//  stalln         in   1     0 = hold PC and IF/ID (load-use stall); 1 = advance
//  redirect_valid in   1     1 = taken branch/jump in EX; flush IF/ID, load redirect_pc
//  redirect_pc    in   XLEN  target; bits [1:0] forced to 0 internally
//  imem_req       out  1     request strobe; accepted in the same cycle, no backpressure
//  imem_addr      out  XLEN  fetch address, equals pc
//  imem_rvalid    in   1     exactly one pulse per request, >=1 cycle after imem_req
//  imem_rdata     in   32    instruction word, valid with imem_rvalid
//  if_id_valid    out  1     IF/ID holds a real instruction
//  if_id_pc       out  XLEN  PC of the instruction in IF/ID
//  if_id_instr    out  32    instruction in IF/ID (NOP_INSTR when invalid)
// BEHAVIOUR
//  Reset (async, immediate): pc=RESET_PC, state=ISSUE, buf empty, if_id_valid=0, if_id_pc=0,
//   if_id_instr=NOP_INSTR; imem_req=0 while rst=1.
//  FSM states: ISSUE, WAIT, FULL, DROP. imem_req = (state==ISSUE) && !redirect_valid && !rst.
//   imem_addr=pc at all times. At most one request outstanding.
//  ISSUE: imem_req=1 -> WAIT.
//  WAIT, imem_rvalid=1, stalln=1: IF/ID <= {1, pc, imem_rdata}; pc<=pc+4; -> ISSUE.
//  WAIT, imem_rvalid=1, stalln=0: IF/ID holds; word+pc saved in 1-entry buf; -> FULL.
//  WAIT, no rvalid: stay.
//  FULL, stalln=1: IF/ID <= buf contents (valid=1); pc<=pc+4; -> ISSUE. stalln=0: stay, IF/ID held.
//  DROP: on imem_rvalid discard data -> ISSUE; else stay.
//  IF/ID when stalln=1 and no word delivered this cycle: if_id_valid<=0, if_id_instr<=NOP_INSTR
//   (bubble); if_id_pc may hold. When stalln=0 all IF/ID fields hold.
//  Redirect (priority over stall and over any delivery in the same cycle):
//   pc<={redirect_pc[XLEN-1:2],2'b00}; if_id_valid<=0, if_id_instr<=NOP_INSTR; buf cleared;
//   ISSUE->ISSUE (no request that cycle); WAIT without rvalid->DROP; WAIT with rvalid->ISSUE
//   (word dropped); FULL->ISSUE; DROP with rvalid->ISSUE; DROP without rvalid->DROP.
//  Latency: request cycle N, rvalid N+k (k>=1), IF/ID valid from N+k+1; with k=1 one
//   instruction per 2 cycles. pc wraps modulo 2^XLEN (0xFFFF_FFFC+4 -> 0).
//  Reset mid-request: in-flight response is the memory's concern; the stage
//   ignores imem_rvalid while in ISSUE.
// STRUCTURE
//  riscv_pkg: XLEN, NOP_INSTR, typedef enum logic [1:0] fetch_state_t {ISSUE,WAIT,FULL,DROP}.
//  One sub-module: if_id_reg (IF/ID register with load/hold/bubble controls, async reset).
//  PC register, buf and FSM live in the top level.
// TESTING
//  1 reset, imem k=1, stalln=1 -> imem_addr 0,4,8; if_id_pc 0,4,8 valid every 2nd cycle.
//  2 rvalid with stalln=0 for 3 cycles -> IF/ID unchanged, no new imem_req; stalln=1 -> word
//    enters IF/ID, imem_req next with pc+4.
//  3 redirect_valid, redirect_pc=0x103 while WAIT (k=3) -> if_id_valid=0, late rvalid ignored,
//    next imem_addr=0x100.
//  4 redirect and stalln=0 same cycle as rvalid -> flush wins, word dropped, imem_addr=target.
//  5 assert rst while in FULL -> all outputs at reset values immediately, imem_addr=RESET_PC.
//  6 pc=0xFFFF_FFFC fetch completes -> next imem_addr=0x0000_0000.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared definitions for the RV32 pipeline front end.
//   XLEN          : data/address width
//   NOP_INSTR     : canonical bubble (addi x0,x0,0) placed in IF/ID when it is empty
//   fetch_state_t : fetch FSM states
package riscv_pkg;

  localparam int          XLEN      = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // ISSUE : a request goes out this cycle (unless redirected)
  // WAIT  : one request outstanding, waiting for imem_rvalid
  // FULL  : a word arrived during a stall and is parked in the skid buffer
  // DROP  : a redirect overtook the outstanding request; its response is discarded
  typedef enum logic [1:0] {
    ISSUE = 2'd0,
    WAIT  = 2'd1,
    FULL  = 2'd2,
    DROP  = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register.
//   clk, rst             : clock, asynchronous active-high reset
//   load                 : capture {load_pc, load_instr} and mark valid
//   bubble               : mark invalid and insert NOP_INSTR (pc is left as is)
//   load_pc, load_instr  : incoming instruction and its address
//   valid, pc, instr     : register contents presented to decode
// With neither load nor bubble asserted every field holds (stall).
module if_id_reg #(
  parameter int          XLEN      = riscv_pkg::XLEN,
  parameter logic [31:0] NOP_INSTR = riscv_pkg::NOP_INSTR
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            bubble,
  input  logic [XLEN-1:0] load_pc,
  input  logic [31:0]     load_instr,
  output logic            valid,
  output logic [XLEN-1:0] pc,
  output logic [31:0]     instr
);

  // Load wins over bubble; the parent never asserts both, but the order
  // keeps the register well defined if it ever did.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      pc    <= '0;
      instr <= NOP_INSTR;
    end else if (load) begin
      valid <= 1'b1;
      pc    <= load_pc;
      instr <= load_instr;
    end else if (bubble) begin
      valid <= 1'b0;
      instr <= NOP_INSTR;
    end
  end

endmodule

// File: rtl/instruction_fetch_stage.sv
// Instruction fetch stage with IF/ID register.
// Owns the PC, keeps at most one request outstanding to instruction memory,
// parks a returned word in a one-entry buffer while decode is stalled, and
// flushes on a redirect from EX.
//   clk, rst        : clock, asynchronous active-high reset
//   stalln          : 0 = hold PC and IF/ID, 1 = advance
//   redirect_valid  : taken branch/jump; flush IF/ID and fetch from redirect_pc
//   redirect_pc     : redirect target (low two bits ignored)
//   imem_req        : request strobe, always accepted
//   imem_addr       : fetch address (the PC)
//   imem_rvalid     : single response pulse per request
//   imem_rdata      : instruction word returned with imem_rvalid
//   if_id_valid     : IF/ID holds a real instruction
//   if_id_pc        : address of the instruction in IF/ID
//   if_id_instr     : instruction in IF/ID (NOP_INSTR when invalid)
module instruction_fetch_stage #(
  parameter int               XLEN      = riscv_pkg::XLEN,
  parameter logic [XLEN-1:0]  RESET_PC  = '0,
  parameter logic [31:0]      NOP_INSTR = riscv_pkg::NOP_INSTR
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stalln,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  output logic            if_id_valid,
  output logic [XLEN-1:0] if_id_pc,
  output logic [31:0]     if_id_instr
);

  import riscv_pkg::*;

  fetch_state_t    state;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] buf_pc;
  logic [31:0]     buf_instr;
  logic [XLEN-1:0] target;
  logic            deliver_now;
  logic            deliver_buf;
  logic            load;
  logic            bubble;
  logic [XLEN-1:0] load_pc;
  logic [31:0]     load_instr;

  assign target    = {redirect_pc[XLEN-1:2], 2'b00};
  assign imem_req  = (state == ISSUE) && !redirect_valid && !rst;
  assign imem_addr = pc;

  // A word reaches IF/ID either straight from memory or from the skid buffer.
  // A redirect in the same cycle cancels the delivery; with no delivery and
  // no stall, a bubble is inserted instead.
  assign deliver_now = (state == WAIT) && imem_rvalid && stalln;
  assign deliver_buf = (state == FULL) && stalln;
  assign load        = !redirect_valid && (deliver_now || deliver_buf);
  assign bubble      = redirect_valid || (stalln && !load);
  assign load_pc     = deliver_buf ? buf_pc : pc;
  assign load_instr  = deliver_buf ? buf_instr : imem_rdata;

  // The PC only advances when its word is handed to IF/ID, so while a
  // request is outstanding pc is still the address of that request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ISSUE;
      pc        <= RESET_PC;
      buf_pc    <= '0;
      buf_instr <= NOP_INSTR;
    end else if (redirect_valid) begin
      pc        <= target;
      buf_pc    <= '0;
      buf_instr <= NOP_INSTR;
      // A request still in flight must have its response swallowed in DROP.
      case (state)
        WAIT, DROP: state <= imem_rvalid ? ISSUE : DROP;
        default:    state <= ISSUE;
      endcase
    end else begin
      case (state)
        ISSUE: state <= WAIT;
        WAIT: begin
          if (imem_rvalid) begin
            if (stalln) begin
              pc    <= pc + XLEN'(4);
              state <= ISSUE;
            end else begin
              buf_pc    <= pc;
              buf_instr <= imem_rdata;
              state     <= FULL;
            end
          end
        end
        FULL: begin
          if (stalln) begin
            pc    <= pc + XLEN'(4);
            state <= ISSUE;
          end
        end
        DROP: begin
          if (imem_rvalid) state <= ISSUE;
        end
        default: state <= ISSUE;
      endcase
    end
  end

  if_id_reg #(
    .XLEN      (XLEN),
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id_reg (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .bubble     (bubble),
    .load_pc    (load_pc),
    .load_instr (load_instr),
    .valid      (if_id_valid),
    .pc         (if_id_pc),
    .instr      (if_id_instr)
  );

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Self-checking bench for instruction_fetch_stage.
// Expected IF/ID contents are queued when the bench returns a word from its
// memory model and popped whenever IF/ID advances with a valid instruction.
module tb_instruction_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        stalln;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        if_id_valid;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_instr;

  int          checks = 0;
  int          errors = 0;
  exp_t        exp_q[$];
  exp_t        mon_exp;
  logic        adv_edge = 1'b0;
  logic [31:0] exp_pc;

  instruction_fetch_stage dut (
    .clk            (clk),
    .rst            (rst),
    .stalln         (stalln),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .if_id_valid    (if_id_valid),
    .if_id_pc       (if_id_pc),
    .if_id_instr    (if_id_instr)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hC0DE_1230;
  endfunction

  // Remember whether the last rising edge was allowed to advance IF/ID.
  always @(posedge clk) adv_edge <= stalln && !rst;

  // Scoreboard: every advancing edge that leaves IF/ID valid must deliver
  // the oldest expected instruction.
  always @(negedge clk) begin
    if (adv_edge && if_id_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL sb_unexpected: got pc=%h instr=%h, required no valid instruction", if_id_pc, if_id_instr);
      end else begin
        mon_exp = exp_q.pop_front();
        if (if_id_pc !== mon_exp.pc || if_id_instr !== mon_exp.instr) begin
          errors++;
          $display("[TB] FAIL sb_ifid: got pc=%h instr=%h, required pc=%h instr=%h", if_id_pc, if_id_instr, mon_exp.pc, mon_exp.instr);
        end
      end
    end
  end

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++; if (imem_req !== 1'b0) begin errors++; $display("[TB] FAIL reset_req: got %b, required 0", imem_req); end
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("[TB] FAIL reset_addr: got %h, required 0", imem_addr); end
    checks++; if (if_id_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b, required 0", if_id_valid); end
    checks++; if (if_id_pc !== 32'h0) begin errors++; $display("[TB] FAIL reset_pc: got %h, required 0", if_id_pc); end
    checks++; if (if_id_instr !== NOP) begin errors++; $display("[TB] FAIL reset_instr: got %h, required %h", if_id_instr, NOP); end
    rst = 1'b0;
    #1;
  endtask

  task automatic test_fetch();
    exp_pc = 32'h0;
    for (int i = 0; i < 3; i++) begin
      checks++; if (imem_req !== 1'b1) begin errors++; $display("[TB] FAIL fetch_req: got %b, required 1", imem_req); end
      checks++; if (imem_addr !== exp_pc) begin errors++; $display("[TB] FAIL fetch_addr: got %h, required %h", imem_addr, exp_pc); end
      @(negedge clk);
      checks++; if (imem_req !== 1'b0) begin errors++; $display("[TB] FAIL fetch_wait_req: got %b, required 0", imem_req); end
      checks++; if (if_id_valid !== 1'b0) begin errors++; $display("[TB] FAIL fetch_bubble: got %b, required 0", if_id_valid); end
      imem_rvalid = 1'b1;
      imem_rdata  = mem_word(exp_pc);
      exp_q.push_back({exp_pc, mem_word(exp_pc)});
      @(negedge clk);
      imem_rvalid = 1'b0;
      checks++; if (if_id_valid !== 1'b1) begin errors++; $display("[TB] FAIL fetch_valid: got %b, required 1", if_id_valid); end
      exp_pc = exp_pc + 32'd4;
    end
  endtask

  task automatic test_stall_hold();
    checks++; if (imem_addr !== 32'h0000_000C) begin errors++; $display("[TB] FAIL stall_start_addr: got %h, required c", imem_addr); end
    @(negedge clk);
    imem_rvalid = 1'b1;
    imem_rdata  = mem_word(32'h0000_000C);
    stalln      = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      imem_rvalid = 1'b0;
      checks++; if (imem_req !== 1'b0) begin errors++; $display("[TB] FAIL stall_req: got %b, required 0", imem_req); end
      checks++; if (if_id_valid !== 1'b0 || if_id_instr !== NOP || if_id_pc !== 32'h8) begin
        errors++; $display("[TB] FAIL stall_hold: got v=%b pc=%h instr=%h, required v=0 pc=8 instr=%h", if_id_valid, if_id_pc, if_id_instr, NOP);
      end
    end
    stalln = 1'b1;
    exp_q.push_back({32'h0000_000C, mem_word(32'h0000_000C)});
    @(negedge clk);
    checks++; if (imem_req !== 1'b1) begin errors++; $display("[TB] FAIL stall_release_req: got %b, required 1", imem_req); end
    checks++; if (imem_addr !== 32'h10) begin errors++; $display("[TB] FAIL stall_release_addr: got %h, required 10", imem_addr); end
    checks++; if (if_id_valid !== 1'b1) begin errors++; $display("[TB] FAIL stall_release_valid: got %b, required 1", if_id_valid); end
  endtask

  task automatic test_redirect_wait();
    @(negedge clk);
    @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0103;
    @(negedge clk);
    redirect_valid = 1'b0;
    checks++; if (if_id_valid !== 1'b0 || if_id_instr !== NOP) begin
      errors++; $display("[TB] FAIL redir_flush: got v=%b instr=%h, required v=0 instr=%h", if_id_valid, if_id_instr, NOP);
    end
    checks++; if (imem_req !== 1'b0) begin errors++; $display("[TB] FAIL redir_drop_req: got %b, required 0", imem_req); end
    imem_rvalid = 1'b1;
    imem_rdata  = mem_word(32'h10);
    @(negedge clk);
    imem_rvalid = 1'b0;
    checks++; if (if_id_valid !== 1'b0) begin errors++; $display("[TB] FAIL redir_late_word: got %b, required 0", if_id_valid); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin
      errors++; $display("[TB] FAIL redir_target: got req=%b addr=%h, required req=1 addr=100", imem_req, imem_addr);
    end
    @(negedge clk);
    imem_rvalid = 1'b1;
    imem_rdata  = mem_word(32'h100);
    exp_q.push_back({32'h100, mem_word(32'h100)});
    @(negedge clk);
    imem_rvalid = 1'b0;
    checks++; if (imem_addr !== 32'h104) begin errors++; $display("[TB] FAIL redir_next_addr: got %h, required 104", imem_addr); end
  endtask

  task automatic test_redirect_stall_same_cycle();
    @(negedge clk);
    imem_rvalid    = 1'b1;
    imem_rdata     = mem_word(32'h104);
    stalln         = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0200;
    @(negedge clk);
    imem_rvalid    = 1'b0;
    stalln         = 1'b1;
    redirect_valid = 1'b0;
    #1;
    checks++; if (if_id_valid !== 1'b0 || if_id_instr !== NOP) begin
      errors++; $display("[TB] FAIL same_cycle_flush: got v=%b instr=%h, required v=0 instr=%h", if_id_valid, if_id_instr, NOP);
    end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin
      errors++; $display("[TB] FAIL same_cycle_target: got req=%b addr=%h, required req=1 addr=200", imem_req, imem_addr);
    end
  endtask

  task automatic test_reset_in_full();
    @(negedge clk);
    imem_rvalid = 1'b1;
    imem_rdata  = mem_word(32'h200);
    stalln      = 1'b0;
    @(negedge clk);
    imem_rvalid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    checks++; if (imem_req !== 1'b0 || imem_addr !== 32'h0) begin
      errors++; $display("[TB] FAIL rst_full_imem: got req=%b addr=%h, required req=0 addr=0", imem_req, imem_addr);
    end
    checks++; if (if_id_valid !== 1'b0 || if_id_pc !== 32'h0 || if_id_instr !== NOP) begin
      errors++; $display("[TB] FAIL rst_full_ifid: got v=%b pc=%h instr=%h, required v=0 pc=0 instr=%h", if_id_valid, if_id_pc, if_id_instr, NOP);
    end
    @(negedge clk);
    stalln = 1'b1;
    rst    = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      errors++; $display("[TB] FAIL rst_release: got req=%b addr=%h, required req=1 addr=0", imem_req, imem_addr);
    end
  endtask

  task automatic test_pc_wrap();
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFF;
    #1;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("[TB] FAIL wrap_redir_req: got %b, required 0", imem_req); end
    @(negedge clk);
    redirect_valid = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFFC) begin
      errors++; $display("[TB] FAIL wrap_start: got req=%b addr=%h, required req=1 addr=fffffffc", imem_req, imem_addr);
    end
    @(negedge clk);
    imem_rvalid = 1'b1;
    imem_rdata  = mem_word(32'hFFFF_FFFC);
    exp_q.push_back({32'hFFFF_FFFC, mem_word(32'hFFFF_FFFC)});
    @(negedge clk);
    imem_rvalid = 1'b0;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      errors++; $display("[TB] FAIL wrap_next: got req=%b addr=%h, required req=1 addr=0", imem_req, imem_addr);
    end
    repeat (2) @(negedge clk);
    checks++; if (exp_q.size() != 0) begin
      errors++; $display("[TB] FAIL sb_leftover: got %0d pending, required 0", exp_q.size());
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, required completion");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    rst            = 1'b1;
    stalln         = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    imem_rvalid    = 1'b0;
    imem_rdata     = 32'h0;
    test_reset();
    test_fetch();
    test_stall_hold();
    test_redirect_wait();
    test_redirect_stall_same_cycle();
    test_reset_in_full();
    test_pc_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
